// File: rtl/types_pkg.sv
// Shared pipeline types for the front end: the fetch beat layout and the
// default reset PC that fetch_queue starts from.
package types_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_4;
      logic [31:0] instr;
   } fetch_data;

   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

   // Instruction addresses are word aligned; the low two bits are dropped.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush and an occupancy count; the head is
// read straight from storage so it never depends on same-cycle inputs.
module sync_fifo #(
   parameter type T     = logic [31:0],
   parameter int  DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  T                           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output T                           head,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   T                mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic            do_push;
   logic            do_pop;

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   always_comb begin
      do_pop  = pop && (count != '0);
      do_push = push && ((count != CW'(DEPTH)) || do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC register, instruction memory request and an
// elastic queue of fetched beats, with redirect that flushes the queue.
module fetch_queue
   import types_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic [31:0]                imem_addr,
   input  logic [31:0]                imem_rdata,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   output logic                       valid_out,
   output fetch_data                  data_out,
   input  logic                       ready_out,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int CW = $clog2(DEPTH+1);

   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        pop;
   logic        push;
   fetch_data   push_data;

   // Redirect wins over fetching; otherwise fetch whenever a slot is free or
   // is being freed by the downstream handshake this cycle.
   always_comb begin
      pop     = valid_out && ready_out;
      push    = !redirect_valid && ((occupancy != CW'(DEPTH)) || pop);
      pc_next = pc;
      if (redirect_valid) begin
         pc_next = align_pc(redirect_pc);
      end else if (push) begin
         pc_next = pc + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

   always_comb begin
      push_data.pc    = pc;
      push_data.pc_4  = pc + 32'd4;
      push_data.instr = imem_rdata;
   end

   sync_fifo #(
      .T     (fetch_data),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (data_out),
      .count     (occupancy)
   );

   assign imem_addr = pc;
   assign valid_out = (occupancy != '0);

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end: PC generator, instruction-memory read, and a DEPTH-entry elastic queue of `fetch_data` beats. It replaces the fixed Fetch + 2-entry skid buffer pairing and adds branch/exception redirect with queue flush. It sits between instruction memory and decode; downstream consumes through the same valid/ready handshake as the existing skid buffer.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥ 2
- `RESET_PC`, 32'h0, PC loaded on reset; bits [1:0] must be 0

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `imem_addr`  out  32  current fetch PC, equal to the internal PC register
- `imem_rdata`  in  32  instruction at `imem_addr`, combinational, same cycle
- `redirect_valid`  in  1  redirect request (mispredict/trap)
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored and treated as 0
- `valid_out`  out  1  queue head valid
- `data_out`  out  `fetch_data`  queue head {pc, pc_4, instr}
- `ready_out`  in  1  downstream ready for `data_out`
- `occupancy`  out  $clog2(DEPTH+1)  current entry count

## Operation
- Reset values: PC = RESET_PC; queue empty; `valid_out`=0; `occupancy`=0; `data_out` don't-care (zero preferred).
- Pop: `valid_out && ready_out`; head removed at the clock edge.
- Push (no redirect): when `occupancy < DEPTH`, or `occupancy == DEPTH` and pop occurs the same cycle. Enqueues {pc=PC, pc_4=PC+4, instr=imem_rdata}. PC <= PC+4 on push, otherwise holds.
- Redirect (highest priority, below reset): queue cleared; PC <= {redirect_pc[31:2],2'b00}; no push that cycle. A pop in the redirect cycle is a completed handshake; the entry is still discarded with the rest.
- Order is strict FIFO; read/write pointers wrap modulo DEPTH.
- `valid_out` = (`occupancy` != 0); head driven from storage, with no combinational path from `imem_rdata` or `ready_out` to `data_out`/`valid_out`.
- PC arithmetic is 32-bit modulo: 0xFFFFFFFC + 4 = 0x00000000.
- Each cycle PC changes only by +4, by redirect load, or by reset load.

## Timing
- Fetch-to-output latency: 1 cycle. A push at edge t is visible at the head after edge t if the queue was empty.
- Steady state with `ready_out`=1: one beat per cycle, no bubbles.
- Full + `ready_out`=0: PC holds, `imem_addr` stable, `occupancy`=DEPTH.
- Full + pop: simultaneous push; occupancy stays DEPTH, throughput 1/cycle.
- Redirect asserted in cycle t: after edge t, `valid_out`=0, `occupancy`=0, `imem_addr`=target. First target beat is valid after edge t+1.
- Back-to-back redirects: the last one wins; each flushes.
- Reset mid-operation: same as power-on reset, regardless of queue or redirect state.
- `occupancy` update: +1 on push only, −1 on pop only, unchanged on both or neither; 0 after redirect.

## Structure
- `fetch_data` (pc, pc_4, instr) stays in `types_pkg`. Add `FETCH_RESET_PC` constant there as the default source for RESET_PC.
- One sub-module: `sync_fifo #(T, DEPTH)` with push/pop/flush, count, and registered head. It is reusable for the decode/rename queues.
- The top level holds the PC register, push/redirect arbitration, and PC alignment.

## Test plan
- Reset released with `ready_out`=1 and a program image loaded: accepted PCs are 0x0, 0x4, 0x8… one per cycle from the second cycle after reset. Each beat has `instr`=image[pc>>2] and `pc_4`=pc+4.
- DEPTH=4, `ready_out`=0 for 8 cycles after reset: `occupancy` goes 1,2,3,4 then holds, and `imem_addr` holds at 0x10. Raising `ready_out` drains 0x0, 0x4, 0x8, 0xC, 0x10, 0x14… with no gap or duplicate.
- `occupancy`=3 and `redirect_valid` with `redirect_pc`=0x100: next cycle `valid_out`=0, `occupancy`=0, `imem_addr`=0x100. The cycle after, the head is pc=0x100. The old entries never appear.
- Full queue with `ready_out`=1 and redirect in the same cycle to 0x203: the head pop counts as accepted. The queue is then empty, and the next head pc is 0x200.
- `redirect_pc`=0xFFFFFFF8 with `ready_out`=1: accepted PCs are 0xFFFFFFF8, 0xFFFFFFFC, then 0x00000000 (wrap). `pc_4` of 0xFFFFFFFC is 0x0.
- `reset` pulsed for 1 cycle while full with a redirect also asserted: after the edge, `occupancy`=0, `valid_out`=0, `imem_addr`=RESET_PC. The redirect is ignored.
